// File: rtl/alu_ext.sv
// alu_ext -- registered ALU with a carry/overflow flag and a sequential
// shift-add multiplier.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   data_hazard  stall: while 1 no new op is accepted
//   op[3:0]      operation select
//   in_a, in_b   WIDTH-bit operands
//   alu_out      registered result (product low half after MUL)
//   hi_out       registered product high half
//   OVF_out      registered carry/overflow flag
//   Z_out        registered zero flag of alu_out
//   N_out        registered negative flag (alu_out MSB)
//   busy         multiply in progress; inputs are ignored while high
//
// Single-cycle ops show their result one clock after acceptance. MUL runs
// WIDTH iterations, one per clock, and loads alu_out/hi_out/flags together
// on the last one.
module alu_ext #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_hazard,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             OVF_out,
  output logic             Z_out,
  output logic             N_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       alu_q, alu_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic                   ovf_q, ovf_d;
  logic                   z_q, z_d;
  logic                   n_q, n_d;
  // Multiplicand latch; the multiplier is latched into the low half of
  // prod_q and consumed one bit per iteration as the product shifts in.
  logic [WIDTH-1:0]       a_q, a_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic                   accept;
  logic [WIDTH:0]         sum_add;
  logic [WIDTH:0]         sum_adc;
  logic [WIDTH:0]         sum_sub;
  logic [WIDTH:0]         step_sum;
  logic [2*WIDTH-1:0]     prod_step;
  logic [WIDTH-1:0]       res;
  logic                   wr;

  assign accept   = (state_q == ST_IDLE) && !data_hazard;

  assign sum_add  = {1'b0, in_a} + {1'b0, in_b};
  assign sum_adc  = sum_add + {{WIDTH{1'b0}}, ovf_q};
  // Bit WIDTH of the difference is the borrow, i.e. set exactly when A < B.
  assign sum_sub  = {1'b0, in_a} - {1'b0, in_b};

  // One shift-add iteration: conditionally add the multiplicand into the
  // upper half, then shift the whole (WIDTH+1)+(WIDTH-1) bit value right.
  assign step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                   + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign prod_step = {step_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    alu_d   = alu_q;
    hi_d    = hi_q;
    ovf_d   = ovf_q;
    z_d     = z_q;
    n_d     = n_q;
    a_d     = a_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    res     = alu_q;
    wr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            4'b0000: begin res = in_a;                     wr = 1'b1; end
            4'b0001: begin res = sum_add[WIDTH-1:0];       wr = 1'b1;
                           ovf_d = sum_add[WIDTH];                    end
            4'b0010: begin res = in_a & in_b;              wr = 1'b1; end
            4'b0011: begin res = in_a ^ in_b;              wr = 1'b1; end
            4'b0100: begin res = in_b;                     wr = 1'b1; end
            4'b0101: begin res = sum_add[WIDTH-1:0];       wr = 1'b1; end
            4'b0110: begin res = in_a | in_b;              wr = 1'b1; end
            4'b0111: begin res = sum_sub[WIDTH-1:0];       wr = 1'b1;
                           ovf_d = sum_sub[WIDTH];                    end
            4'b1000: begin res = sum_adc[WIDTH-1:0];       wr = 1'b1;
                           ovf_d = sum_adc[WIDTH];                    end
            4'b1001: begin res = {in_a[WIDTH-2:0], 1'b0};  wr = 1'b1;
                           ovf_d = in_a[WIDTH-1];                     end
            4'b1010: begin res = {1'b0, in_a[WIDTH-1:1]};  wr = 1'b1;
                           ovf_d = in_a[0];                           end
            // Rotate left through the flag: old flag enters the LSB.
            4'b1011: begin res = {in_a[WIDTH-2:0], ovf_q}; wr = 1'b1;
                           ovf_d = in_a[WIDTH-1];                     end
            4'b1100: begin
              // With the multiplier disabled this encoding does nothing.
              if (MUL_EN) begin
                state_d = ST_MUL;
                a_d     = in_a;
                prod_d  = {{WIDTH{1'b0}}, in_b};
                cnt_d   = '0;
              end
            end
            4'b1101: ovf_d = 1'b0;
            4'b1110: begin res = hi_q;                     wr = 1'b1; end
            default: ;
          endcase
        end
      end

      ST_MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Last iteration: publish the finished product directly from
          // the combinational step so it lands exactly WIDTH edges in.
          state_d = ST_IDLE;
          res     = prod_step[WIDTH-1:0];
          wr      = 1'b1;
          hi_d    = prod_step[2*WIDTH-1:WIDTH];
          ovf_d   = |prod_step[2*WIDTH-1:WIDTH];
        end
      end
    endcase

    if (wr) begin
      alu_d = res;
      z_d   = (res == '0);
      n_d   = res[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      alu_q   <= '0;
      hi_q    <= '0;
      ovf_q   <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      a_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      hi_q    <= hi_d;
      ovf_q   <= ovf_d;
      z_q     <= z_d;
      n_q     <= n_d;
      a_q     <= a_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_out = alu_q;
  assign hi_out  = hi_q;
  assign OVF_out = ovf_q;
  assign Z_out   = z_q;
  assign N_out   = n_q;
  assign busy    = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_ext.sv
// tb_alu_ext -- self-checking bench for alu_ext (WIDTH=8). A behavioural
// model tracks the expected outputs with plain integer arithmetic; every
// clock all outputs are compared against it, plus directed value checks.
module tb_alu_ext;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         data_hazard;
  logic [3:0]   op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] alu_out;
  logic [W-1:0] hi_out;
  logic         OVF_out;
  logic         Z_out;
  logic         N_out;
  logic         busy;

  alu_ext #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_hazard (data_hazard),
    .op          (op),
    .in_a        (in_a),
    .in_b        (in_b),
    .alu_out     (alu_out),
    .hi_out      (hi_out),
    .OVF_out     (OVF_out),
    .Z_out       (Z_out),
    .N_out       (N_out),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  int m_alu, m_hi, m_ovf, m_z, m_n;
  int m_busy_left;
  int m_pa, m_pb;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_alu = 0; m_hi = 0; m_ovf = 0; m_z = 0; m_n = 0;
    m_busy_left = 0; m_pa = 0; m_pb = 0;
  endtask

  task automatic model_set_alu(input int v);
    m_alu = v & 255;
    m_z   = (m_alu == 0) ? 1 : 0;
    m_n   = (m_alu >= 128) ? 1 : 0;
  endtask

  // Apply one rising edge to the model, given the inputs seen at that edge.
  task automatic model_edge(input int o, input int a, input int b, input int hz);
    int s;
    longint p;
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        p = longint'(m_pa) * longint'(m_pb);
        m_hi  = int'((p >> 8) & 255);
        m_ovf = (m_hi != 0) ? 1 : 0;
        model_set_alu(int'(p & 255));
      end
    end else if (hz == 0) begin
      case (o)
        0:  model_set_alu(a);
        1:  begin s = a + b; m_ovf = (s > 255) ? 1 : 0; model_set_alu(s); end
        2:  model_set_alu(a & b);
        3:  model_set_alu(a ^ b);
        4:  model_set_alu(b);
        5:  model_set_alu(a + b);
        6:  model_set_alu(a | b);
        7:  begin m_ovf = (a < b) ? 1 : 0; model_set_alu(a - b); end
        8:  begin s = a + b + m_ovf; m_ovf = (s > 255) ? 1 : 0; model_set_alu(s); end
        9:  begin m_ovf = a / 128; model_set_alu(a * 2); end
        10: begin m_ovf = a % 2; model_set_alu(a / 2); end
        11: begin s = a * 2 + m_ovf; m_ovf = a / 128; model_set_alu(s); end
        12: begin m_busy_left = W; m_pa = a; m_pb = b; end
        13: m_ovf = 0;
        14: model_set_alu(m_hi);
        default: ;
      endcase
    end
  endtask

  task automatic compare_all(input string where);
    check({where, ".alu"},  int'(alu_out), m_alu);
    check({where, ".hi"},   int'(hi_out),  m_hi);
    check({where, ".ovf"},  int'(OVF_out), m_ovf);
    check({where, ".z"},    int'(Z_out),   m_z);
    check({where, ".n"},    int'(N_out),   m_n);
    check({where, ".busy"}, int'(busy),    (m_busy_left > 0) ? 1 : 0);
  endtask

  // One clock: drive inputs, advance DUT and model, compare after the edge.
  task automatic cyc(input int o, input int a, input int b, input int hz, input string where);
    op          = o[3:0];
    in_a        = a[W-1:0];
    in_b        = b[W-1:0];
    data_hazard = hz[0];
    @(posedge clk);
    model_edge(o, a, b, hz);
    #1;
    compare_all(where);
    $display("cyc %s op=%0h a=%02h b=%02h hz=%0d -> alu=%02h hi=%02h ovf=%0d z=%0d n=%0d busy=%0d",
             where, o, a, b, hz, alu_out, hi_out, OVF_out, Z_out, N_out, busy);
  endtask

  task automatic cyc_rand(input string where);
    cyc(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
        int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), where);
  endtask

  // Launch a MUL and run it to completion with random traffic on the inputs;
  // returns how many sampled cycles busy was high.
  task automatic do_mul(input int a, input int b, output int len);
    int guard;
    len = 0;
    cyc(12, a, b, 0, "mul_go");
    if (busy) len++;
    guard = 0;
    while (busy && guard < 40) begin
      cyc_rand("mul_run");
      if (busy) len++;
      guard++;
    end
    if (guard >= 40) check("mul_timeout", 1, 0);
  endtask

  int len;
  int hold_alu;

  initial begin
    rst = 1'b1; data_hazard = 1'b0; op = 4'h0; in_a = '0; in_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b0;

    // Add with carry out, then add leaving the flag alone.
    cyc(1, 'hF0, 'h20, 0, "add");
    check("add.alu", int'(alu_out), 'h10);
    check("add.ovf", int'(OVF_out), 1);
    check("add.z",   int'(Z_out),   0);
    check("add.n",   int'(N_out),   0);
    cyc(5, 'hFF, 'h01, 0, "addnf");
    check("addnf.alu", int'(alu_out), 'h00);
    check("addnf.z",   int'(Z_out),   1);
    check("addnf.ovf", int'(OVF_out), 1);

    // Subtract with borrow, then add-with-carry consuming the flag.
    cyc(7, 'h05, 'h07, 0, "sub");
    check("sub.alu", int'(alu_out), 'hFE);
    check("sub.ovf", int'(OVF_out), 1);
    check("sub.n",   int'(N_out),   1);
    cyc(8, 'h01, 'h01, 0, "adc");
    check("adc.alu", int'(alu_out), 'h03);
    check("adc.ovf", int'(OVF_out), 0);

    // Full-scale multiply with noise on the inputs while busy.
    do_mul('hFF, 'hFF, len);
    check("mul1.len", len, 8);
    check("mul1.alu", int'(alu_out), 'h01);
    check("mul1.hi",  int'(hi_out),  'hFE);
    check("mul1.ovf", int'(OVF_out), 1);
    // Accepted on the edge right after busy falls.
    cyc(1, 'h12, 'h34, 0, "after_mul");
    check("after_mul.alu", int'(alu_out), 'h46);

    do_mul('h0F, 'h11, len);
    check("mul2.len", len, 8);
    check("mul2.alu", int'(alu_out), 'hFF);
    check("mul2.hi",  int'(hi_out),  'h00);
    check("mul2.ovf", int'(OVF_out), 0);
    check("mul2.n",   int'(N_out),   1);

    // Stall for three cycles, then release.
    hold_alu = int'(alu_out);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 'h30, 'h40, 1, "hazard");
      check("hazard.alu", int'(alu_out), hold_alu);
    end
    cyc(1, 'h30, 'h40, 0, "release");
    check("release.alu", int'(alu_out), 'h70);

    // Reset in the middle of a multiply.
    cyc(12, 'hAB, 'hCD, 0, "mul3_go");
    for (int i = 0; i < 3; i++) cyc_rand("mul3_run");
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_mid.busy", int'(busy),    0);
    check("rst_mid.alu",  int'(alu_out), 0);
    check("rst_mid.hi",   int'(hi_out),  0);
    check("rst_mid.ovf",  int'(OVF_out), 0);
    check("rst_mid.zn",   int'({Z_out, N_out}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(14, 'h55, 'h66, 0, "hi_after_rst");
    check("hi_after_rst.alu", int'(alu_out), 'h00);
    check("hi_after_rst.z",   int'(Z_out),   1);
    cyc(1, 'h05, 'h06, 0, "add_after_rst");
    check("add_after_rst.alu", int'(alu_out), 'h0B);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) cyc_rand("rand");

    // Let any trailing multiply finish.
    for (int i = 0; i < 10; i++) cyc(15, 0, 0, 0, "drain");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
